// File: rtl/fir_pkg.sv
// fir_pkg: state encoding and shared constants for the FIR sequencer.
package fir_pkg;
  typedef enum logic [2:0] {IDLE, CLR, WAIT_X, MAC, OUT, DONE} state_t;
  localparam int TAPE_NUM = 11;
  localparam int ADDR_STRIDE = 4;
endpackage

// File: rtl/fir_ring_ptr.sv
// fir_ring_ptr: modulo-N index register with wrap increment and a modular offset subtract.
module fir_ring_ptr #(
  parameter int N = 11,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] off,
  output logic [W-1:0] idx,
  output logic [W-1:0] sub
);
  logic [W:0] diff;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) idx <= '0;
    else if (clr) idx <= '0;
    else if (inc) idx <= (idx == W'(N - 1)) ? '0 : idx + W'(1);
  // a borrow out of the subtract means we wrapped below zero: add N back
  assign diff = {1'b0, idx} - {1'b0, off};
  assign sub = diff[W] ? W'(diff + (W + 1)'(N)) : diff[W-1:0];
endmodule

// File: rtl/fir_ctrl.sv
// fir_ctrl: FIR sequencer - clears the data ring, stores each sample, steps Tape_Num MAC
// addresses per sample and hands y to the output stream under ap_start/ap_idle/ap_done control.
module fir_ctrl
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num = TAPE_NUM
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ap_start,
  input  logic [pDATA_WIDTH-1:0] data_length,
  output logic                   ap_idle,
  output logic                   ap_done,
  input  logic                   strm_valid,
  output logic                   fir_ready,
  output logic                   data_we,
  output logic                   data_zero,
  output logic [pADDR_WIDTH-1:0] data_addr,
  output logic [pADDR_WIDTH-1:0] tap_addr,
  output logic                   mac_clr,
  output logic                   mac_en,
  output logic                   y_valid,
  output logic                   y_last,
  input  logic                   y_ready
);
  localparam int IW = $clog2(Tape_Num);
  localparam int CW = $clog2(Tape_Num + 1);
  localparam logic [CW-1:0] LAST_C = CW'(Tape_Num - 1);
  localparam logic [CW-1:0] END_K = CW'(Tape_Num);
  state_t state;
  logic [CW-1:0] cnt;
  logic [pDATA_WIDTH-1:0] len, sample_cnt;
  logic [IW-1:0] wptr, rd_idx;
  logic accept, tap_phase;
  function automatic logic [pADDR_WIDTH-1:0] baddr(input logic [CW-1:0] i);
    return pADDR_WIDTH'(i) * pADDR_WIDTH'(ADDR_STRIDE);
  endfunction
  fir_ring_ptr #(.N(Tape_Num), .W(IW)) u_ring (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == CLR),
    .inc   (y_valid && y_ready),
    .off   (IW'(cnt)),
    .idx   (wptr),
    .sub   (rd_idx)
  );
  // the sample write happens in the accept cycle itself, so the WAIT_X strobes follow strm_valid
  assign fir_ready = state == WAIT_X;
  assign accept = fir_ready && strm_valid;
  assign tap_phase = state == MAC && cnt != END_K;
  assign data_we = state == CLR || accept;
  assign data_zero = state == CLR;
  assign mac_clr = accept;
  assign y_valid = state == OUT;
  assign y_last = y_valid && sample_cnt == len - pDATA_WIDTH'(1);
  assign tap_addr = tap_phase ? baddr(cnt) : '0;
  assign data_addr = state == CLR ? baddr(cnt) :
                     fir_ready ? baddr(CW'(wptr)) :
                     tap_phase ? baddr(CW'(rd_idx)) : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      len <= '0;
      sample_cnt <= '0;
      ap_idle <= 1'b1;
      ap_done <= 1'b0;
      mac_en <= 1'b0;
    end else begin
      mac_en <= tap_phase;
      case (state)
        IDLE: if (ap_start) begin
          len <= data_length;
          sample_cnt <= '0;
          ap_done <= 1'b0;
          ap_idle <= 1'b0;
          cnt <= '0;
          state <= CLR;
        end
        CLR: if (cnt == LAST_C) begin
          cnt <= '0;
          state <= len == '0 ? DONE : WAIT_X;
        end else cnt <= cnt + CW'(1);
        WAIT_X: if (strm_valid) begin
          cnt <= '0;
          state <= MAC;
        end
        MAC: if (cnt == END_K) state <= OUT;
          else cnt <= cnt + CW'(1);
        OUT: if (y_ready) begin
          sample_cnt <= sample_cnt + pDATA_WIDTH'(1);
          state <= y_last ? DONE : WAIT_X;
        end
        DONE: begin
          ap_done <= 1'b1;
          ap_idle <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fir_ctrl.sv
// tb_fir_ctrl: directed and randomized checks of fir_ctrl against a behavioural reference model.
module tb_fir_ctrl;
  localparam int T = 11;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int M_IDLE = 0, M_CLR = 1, M_WAIT = 2, M_MAC = 3, M_OUT = 4, M_DONE = 5;
  logic clk = 0, rst_n = 0, ap_start = 0, strm_valid = 0, y_ready = 0;
  logic [DW-1:0] data_length = '0;
  logic ap_idle, ap_done, fir_ready, data_we, data_zero, mac_clr, mac_en, y_valid, y_last;
  logic [AW-1:0] data_addr, tap_addr;
  int checks = 0, errors = 0;
  int exp_rd[11] = '{8, 4, 0, 40, 36, 32, 28, 24, 20, 16, 12};
  always #5 clk = ~clk;

  fir_ctrl #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(T)) dut (
    .clk(clk), .rst_n(rst_n), .ap_start(ap_start), .data_length(data_length),
    .ap_idle(ap_idle), .ap_done(ap_done), .strm_valid(strm_valid), .fir_ready(fir_ready),
    .data_we(data_we), .data_zero(data_zero), .data_addr(data_addr), .tap_addr(tap_addr),
    .mac_clr(mac_clr), .mac_en(mac_en), .y_valid(y_valid), .y_last(y_last), .y_ready(y_ready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", nm, act, exp_v, $time);
    end
  endtask

  // reference model: phase of the run, position within it, write slot, samples emitted
  int md = M_IDLE, k = 0, wp = 0, ns = 0, ln = 0;
  bit m_idle = 1, m_done = 0, m_mac_en = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      md <= M_IDLE; k <= 0; wp <= 0; ns <= 0; ln <= 0;
      m_idle <= 1; m_done <= 0; m_mac_en <= 0;
    end else begin
      m_mac_en <= md == M_MAC && k < T;
      case (md)
        M_IDLE: if (ap_start) begin
          ln <= int'(data_length); ns <= 0; m_done <= 0; m_idle <= 0; k <= 0; md <= M_CLR;
        end
        M_CLR: if (k == T - 1) begin
          k <= 0; wp <= 0; md <= (ln == 0) ? M_DONE : M_WAIT;
        end else k <= k + 1;
        M_WAIT: if (strm_valid) begin k <= 0; md <= M_MAC; end
        M_MAC: if (k == T) md <= M_OUT; else k <= k + 1;
        M_OUT: if (y_ready) begin
          wp <= (wp + 1) % T; ns <= ns + 1; md <= (ns == ln - 1) ? M_DONE : M_WAIT;
        end
        M_DONE: begin m_done <= 1; m_idle <= 1; md <= M_IDLE; end
        default: md <= M_IDLE;
      endcase
    end

  logic [AW-1:0] pda = '0, pta = '0;
  bit pout = 0;
  always @(negedge clk) begin
    chk("ap_idle", ap_idle, m_idle);
    chk("ap_done", ap_done, m_done);
    chk("fir_ready", fir_ready, md == M_WAIT);
    chk("data_we", data_we, md == M_CLR || (md == M_WAIT && strm_valid));
    chk("data_zero", data_zero, md == M_CLR);
    chk("mac_clr", mac_clr, md == M_WAIT && strm_valid);
    chk("mac_en", mac_en, m_mac_en);
    chk("y_valid", y_valid, md == M_OUT);
    if (md == M_CLR) chk("clr_addr", data_addr, 4 * k);
    if (md == M_WAIT) chk("wr_addr", data_addr, 4 * wp);
    if (md == M_MAC && k < T) begin
      chk("rd_addr", data_addr, 4 * ((wp - k + T) % T));
      chk("tap_addr", tap_addr, 4 * k);
    end
    if (md == M_OUT) chk("y_last", y_last, ns == ln - 1);
    if (md == M_OUT && pout) begin
      chk("out_daddr_frozen", data_addr, pda);
      chk("out_taddr_frozen", tap_addr, pta);
    end
    if (!rst_n) begin
      chk("rst_daddr", data_addr, 0);
      chk("rst_taddr", tap_addr, 0);
      chk("rst_ylast", y_last, 0);
    end
    pout <= md == M_OUT;
    pda <= data_addr;
    pta <= tap_addr;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int len);
    ap_start = 1;
    data_length = DW'(len);
    tick;
    ap_start = 0;
    repeat (T) tick;
  endtask

  task automatic do_sample(input bit lit, input int hold, input bit poke);
    logic [AW-1:0] da[11];
    logic [AW-1:0] ta[11];
    int pulses;
    bit got;
    got = 0;
    pulses = 0;
    strm_valid = 1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (fir_ready) got = 1;
      else tick;
    end
    chk("ready_wait", got, 1);
    tick;
    strm_valid = 0;
    for (int i = 0; i < 12; i++) begin
      ap_start = poke && i == 3;
      if (poke && i == 3) data_length = 99;
      @(negedge clk);
      if (i < 11) begin
        da[i] = data_addr;
        ta[i] = tap_addr;
      end
      pulses += int'(mac_en);
      tick;
    end
    ap_start = 0;
    if (lit) begin
      for (int i = 0; i < 11; i++) begin
        chk("rd_addr_lit", da[i], exp_rd[i]);
        chk("tap_addr_lit", ta[i], 4 * i);
      end
      chk("mac_en_pulses", pulses, 11);
    end
    for (int h = 0; h <= hold; h++) begin
      y_ready = h == hold;
      @(negedge clk);
      chk("y_valid_hold", y_valid, 1);
      if (h < hold) chk("ready_in_out", fir_ready, 0);
      tick;
    end
    y_ready = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick;
    @(negedge clk);
    chk("rst_idle_lit", ap_idle, 1);
    chk("rst_done_lit", ap_done, 0);
    chk("rst_we_lit", data_we, 0);
    chk("rst_yv_lit", y_valid, 0);
    tick;
    rst_n = 1;
    tick;
    ap_start = 1;
    data_length = 3;
    @(negedge clk);
    chk("idle_before_lit", ap_idle, 1);
    tick;
    ap_start = 0;
    data_length = 0;
    for (int c = 0; c < T; c++) begin
      @(negedge clk);
      chk("clr_we_lit", data_we, 1);
      chk("clr_zero_lit", data_zero, 1);
      chk("clr_addr_lit", data_addr, 4 * c);
      chk("clr_busy_lit", ap_idle, 0);
      tick;
    end
    @(negedge clk);
    chk("ready_after_clr_lit", fir_ready, 1);
    tick;
    do_sample(0, 0, 0);
    do_sample(0, 5, 1);
    @(negedge clk);
    chk("wait_after_out_lit", fir_ready, 1);
    tick;
    do_sample(1, 0, 0);
    @(negedge clk);
    chk("done_cycle_yv_lit", y_valid, 0);
    tick;
    @(negedge clk);
    chk("done_flag_lit", ap_done, 1);
    chk("idle_flag_lit", ap_idle, 1);
    tick;
    start_run(12);
    repeat (12) do_sample(0, int'($urandom_range(0, 2)), 0);
    tick;
    repeat (4) begin
      @(negedge clk);
      chk("done_sticky_lit", ap_done, 1);
      tick;
    end
    start_run(0);
    @(negedge clk);
    chk("len0_yv_lit", y_valid, 0);
    chk("len0_ready_lit", fir_ready, 0);
    chk("len0_done_cleared_lit", ap_done, 0);
    tick;
    @(negedge clk);
    chk("len0_done_lit", ap_done, 1);
    tick;
    start_run(2);
    strm_valid = 1;
    tick;
    strm_valid = 0;
    repeat (4) tick;
    rst_n = 0;
    @(negedge clk);
    chk("midrun_rst_mac_en_lit", mac_en, 0);
    chk("midrun_rst_daddr_lit", data_addr, 0);
    chk("midrun_rst_idle_lit", ap_idle, 1);
    chk("midrun_rst_done_lit", ap_done, 0);
    tick;
    rst_n = 1;
    ap_start = 1;
    data_length = 1;
    tick;
    ap_start = 0;
    @(negedge clk);
    chk("restart_zero_lit", data_zero, 1);
    chk("restart_addr_lit", data_addr, 0);
    repeat (T) tick;
    do_sample(0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      ap_start = $urandom_range(0, 7) == 0;
      data_length = DW'($urandom_range(0, 14));
      strm_valid = 1'($urandom_range(0, 1));
      y_ready = 1'($urandom_range(0, 1));
      tick;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
